// File: rtl/mem_copy_engine.sv
// Block-copy bus master for the single-port data memory: reads src+idx, writes dst+idx, one word per RD/WR pair.
// Optional `CHECKSUM_EN adds a running sum of copied words on port checksum.
module mem_copy_engine #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [LEN_W-1:0]  idx_next;
    logic [LEN_W-1:0]  len_clamped;

    always_comb begin
        len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
        idx_next    = idx + LEN_W'(1);
    end

    // Read data arrives registered during WR, so the write data is a gated pass-through.
    always_comb begin
        mem_wdata = '0;
        if (state == WR)
            mem_wdata = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
`ifdef CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        len_q <= len_clamped;
                        idx   <= '0;
`ifdef CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (len_clamped != '0) begin
                            state    <= RD;
                            busy     <= 1'b1;
                            mem_addr <= src_addr;
                            mem_we   <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state    <= WR;
                    mem_addr <= dst_q + ADDR_W'(idx);
                    mem_we   <= 1'b1;
                end
                WR: begin
`ifdef CHECKSUM_EN
                    checksum <= checksum + mem_rdata;
`endif
                    if (idx_next == len_q) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        idx      <= idx_next;
                        state    <= RD;
                        mem_we   <= 1'b0;
                        mem_addr <= src_q + ADDR_W'(idx_next);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory plus an array-level copy model; cycle-by-cycle bus checks.
module tb_mem_copy_engine;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
`ifdef CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    // Single-port memory with registered read; the bench preloads through the ld port.
    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (mem_we === 1'b1)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = ADDR_W'(a);
        ld_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++)
            poke(i, $urandom);
    endtask

    // Reference: word-by-word ascending copy on the array, so overlaps behave as the bus would.
    task automatic model_copy(input int src, input int dst, input int ln, output logic [31:0] sum);
        int l;
        logic [31:0] v;
        l   = (ln > DEPTH) ? DEPTH : ln;
        sum = 0;
        for (int i = 0; i < l; i++) begin
            v = ref_mem[(src + i) % DEPTH];
            ref_mem[(dst + i) % DEPTH] = v;
            sum += v;
        end
    endtask

    task automatic compare_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic run_copy(input string tag, input int src, input int dst, input int ln, input bit mid_start);
        int l, done_cycle, done_count, bus_err, we_cnt, k;
        logic [31:0] exp_sum;
        int exp_addr;
        l = (ln > DEPTH) ? DEPTH : ln;
        model_copy(src, dst, ln, exp_sum);
        done_cycle = -1;
        done_count = 0;
        bus_err    = 0;
        we_cnt     = 0;
        start    = 1'b1;
        src_addr = ADDR_W'(src);
        dst_addr = ADDR_W'(dst);
        len      = LEN_W'(ln);
        for (int c = 1; c <= 2 * l + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (mem_we === 1'b1) we_cnt++;
            if (c <= 2 * l) begin
                k = (c - 1) / 2;
                exp_addr = (c % 2 == 1) ? (src + k) % DEPTH : (dst + k) % DEPTH;
                if (32'(mem_addr) !== exp_addr || mem_we !== (c % 2 == 0) || busy !== 1'b1)
                    bus_err++;
            end else if (mem_addr !== '0 || mem_we !== 1'b0 || busy !== 1'b0 || mem_wdata !== '0) begin
                bus_err++;
            end
`ifdef CHECKSUM_EN
            if (c == 1 && l > 0) check({tag, "_cksum_clear"}, checksum, 0);
            if (c == 2 * l + 2) check({tag, "_cksum"}, checksum, exp_sum);
`endif
            if (mid_start && c == 3) begin
                start    = 1'b1;
                src_addr = ADDR_W'($urandom);
                dst_addr = ADDR_W'($urandom);
                len      = 8'd5;
            end
        end
        check({tag, "_done_cycle"}, done_cycle, 2 * l + 1);
        check({tag, "_done_count"}, done_count, 1);
        check({tag, "_we_count"}, we_cnt, l);
        check({tag, "_bus"}, bus_err, 0);
        compare_mem({tag, "_mem"});
    endtask

    task automatic reset_mid_copy();
        logic [31:0] dummy;
        int done_count = 0;
        fill_random();
        model_copy(30, 90, 2, dummy);
        start = 1'b1; src_addr = 7'd30; dst_addr = 7'd90; len = 8'd8;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_we", 32'(mem_we), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(mem_addr), 0);
`ifdef CHECKSUM_EN
        check("rst_cksum", checksum, 0);
`endif
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_count++;
        end
        check("rst_no_done", done_count, 0);
        compare_mem("rst_mem");
    endtask

    initial begin
        logic [31:0] s;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("init_busy", 32'(busy), 0);
        check("init_done", 32'(done), 0);
        check("init_we", 32'(mem_we), 0);
        check("init_addr", 32'(mem_addr), 0);
        check("init_wdata", mem_wdata, 0);

        fill_random();
        poke(10, 32'hA); poke(11, 32'hB); poke(12, 32'hC); poke(13, 32'hD);
        run_copy("basic", 10, 40, 4, 1'b0);
        check("basic_dst", mem[41], 32'hB);

        run_copy("len0", 5, 6, 0, 1'b0);

        poke(126, 1); poke(127, 2); poke(0, 3); poke(1, 4);
        run_copy("wrap", 126, 60, 4, 1'b0);
        check("wrap_dst", mem[63], 4);

        poke(20, 32'h55);
        run_copy("overlap", 20, 21, 3, 1'b1);
        check("overlap_dst", mem[23], 32'h55);

        reset_mid_copy();

        poke(0, 32'hFFFF_FFFF); poke(1, 2); poke(2, 3);
        run_copy("sum", 0, 64, 3, 1'b0);
`ifdef CHECKSUM_EN
        check("sum_value", checksum, 4);
`endif
        run_copy("same", 50, 50, 10, 1'b0);
        run_copy("clamp", 3, 100, 200, 1'b0);

        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0) fill_random();
            run_copy("rand", int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 140)), 1'b0);
        end
        model_copy(0, 0, 0, s);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
